ysyx_25030093_trap_seq: RTL and testbench
=========================================

YSYX_25030093_TRAP_SEQ -- requirements
Module: ysyx_25030093_trap_seq

Interface
REQ-001 SHALL have parameter MCAUSE_ECALL, default 32'd11, the mcause value written on ecall.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-004 SHALL have ports ecall_req / mret_req  in  1 each  trap entry / trap return request, level, held until ack.
REQ-005 SHALL have port cur_pc  in  32  PC of the requesting instruction, valid while a request is high.
REQ-006 SHALL have ports trap_ack  out  1  accept pulse; busy  out  1  sequencer active, pipeline stalls.
REQ-007 SHALL have ports redirect_valid  out  1  one-cycle pulse; redirect_pc  out  32  next-fetch PC.
REQ-008 SHALL have ports sw_wen  in  1, sw_addr  in  12, sw_wdata  in  32, sw_ready  out  1  CSR-instruction write request.
REQ-009 SHALL have ports sw_raddr  in  12, sw_rdata  out  32  CSR-instruction read path.
REQ-010 SHALL have ports csr_wen  out  1, csr_waddr  out  12, csr_wdata  out  32, csr_raddr  out  12  to the CSR file.
REQ-011 SHALL have port csr_rdata  in  32  combinational read data of the CSR file at csr_raddr.

Function
REQ-012 SHALL implement FSM states IDLE, E_EPC, E_CAUSE, E_STAT, E_JUMP, M_STAT, M_JUMP.
REQ-013 In IDLE with ecall_req, SHALL pulse trap_ack, latch cur_pc, go E_EPC; ecall wins when ecall_req and mret_req are both high.
REQ-014 In IDLE with only mret_req, SHALL pulse trap_ack and go M_STAT.
REQ-015 E_EPC: write mepc (0x341) = latched PC; E_CAUSE: write mcause (0x342) = MCAUSE_ECALL.
REQ-016 E_STAT: raddr mstatus (0x300); write back with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(12:11)=2'b11, other bits unchanged.
REQ-017 E_JUMP: raddr mtvec (0x305); redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}; next state IDLE.
REQ-018 M_STAT: RMW mstatus with MIE=old MPIE, MPIE=1, MPP=2'b11; M_JUMP: raddr mepc, redirect_valid=1, redirect_pc=csr_rdata; next IDLE.
REQ-019 Latency: ecall ack at cycle T, redirect at T+4; mret ack at T, redirect at T+2; exactly one CSR write per write state.
REQ-020 busy SHALL be 1 in every non-IDLE state and in the ack cycle; 0 otherwise.
REQ-021 sw_ready SHALL be 1 only in IDLE with no trap request; csr write follows sw_wen/sw_addr/sw_wdata combinationally then.
REQ-022 When sw_wen coincides with a trap request, SHALL accept the trap, drop nothing silently: sw_ready=0, requester retries.
REQ-023 In IDLE, csr_raddr SHALL equal sw_raddr; sw_rdata SHALL always equal csr_rdata (valid only when sw_ready=1).
REQ-024 Requests arriving in non-IDLE states SHALL be ignored until IDLE; no queuing.
REQ-025 csr_wen SHALL be 0 in E_JUMP and M_JUMP and in IDLE without an accepted sw write.

Reset
REQ-026 On rst: state=IDLE, latched PC=0, trap_ack=0, busy=0, redirect_valid=0, redirect_pc=0, csr_wen=0.
REQ-027 Reset mid-sequence SHALL abort with no further CSR writes and no redirect pulse; partial writes stand.

Structure
REQ-028 CSR addresses (MTVEC, MEPC, MCAUSE, MSTATUS), mstatus bit indices and the state enum SHALL live in shared package ysyx_25030093_csr_pkg.
REQ-029 Single module; mstatus bit manipulation MAY be a sub-module ysyx_25030093_mstatus_upd (mode in, old value in, new value out).

Verification
REQ-030 mtvec=0x80000100, mstatus=0x1808, ecall at pc 0x80000040 -> mepc=0x80000040, mcause=11, mstatus=0x1880, redirect 0x80000100 at T+4.
REQ-031 mepc=0x80000044, mstatus=0x1880, mret -> mstatus=0x1888, redirect_valid at T+2 with redirect_pc=0x80000044.
REQ-032 ecall_req and mret_req high same cycle -> ecall sequence only; mret served after ecall_req drops.
REQ-033 sw_wen to mscratch 0x340 with ecall_req same cycle -> sw_ready=0, trap ack; retried write lands after redirect cycle.
REQ-034 rst asserted in E_CAUSE -> mepc written, mcause unchanged, no redirect_valid, state IDLE immediately.
REQ-035 mtvec=0x80000103 -> redirect_pc=0x80000100.

Source files
------------

// File: rtl/ysyx_25030093_csr_pkg.sv
// Shared CSR addresses, mstatus field positions and trap sequencer states.
package ysyx_25030093_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE,
        E_EPC,
        E_CAUSE,
        E_STAT,
        E_JUMP,
        M_STAT,
        M_JUMP
    } trap_state_t;

    typedef enum logic {
        MODE_TRAP = 1'b0,
        MODE_RET  = 1'b1
    } mstat_mode_t;

endpackage

// File: rtl/ysyx_25030093_mstatus_upd.sv
// mstatus read-modify-write for trap entry (mode=0) and mret (mode=1).
module ysyx_25030093_mstatus_upd
    import ysyx_25030093_csr_pkg::*;
(
    input  logic        mode,
    input  logic [31:0] old_val,
    output logic [31:0] new_val
);

    always_comb begin
        new_val = old_val;
        new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (mode == MODE_RET) begin
            new_val[MSTATUS_MIE]  = old_val[MSTATUS_MPIE];
            new_val[MSTATUS_MPIE] = 1'b1;
        end else begin
            new_val[MSTATUS_MPIE] = old_val[MSTATUS_MIE];
            new_val[MSTATUS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_25030093_trap_seq.sv
// Multi-cycle ecall/mret sequencer: one CSR write per cycle, then a redirect.
module ysyx_25030093_trap_seq
    import ysyx_25030093_csr_pkg::*;
#(
    parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_req,
    input  logic        mret_req,
    input  logic [31:0] cur_pc,
    output logic        trap_ack,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        sw_wen,
    input  logic [11:0] sw_addr,
    input  logic [31:0] sw_wdata,
    output logic        sw_ready,
    input  logic [11:0] sw_raddr,
    output logic [31:0] sw_rdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata
);

    trap_state_t state, state_nxt;
    logic [31:0] epc_q;
    logic        upd_mode;
    logic [31:0] mstat_new;

    ysyx_25030093_mstatus_upd u_mstatus_upd (
        .mode    (upd_mode),
        .old_val (csr_rdata),
        .new_val (mstat_new)
    );

    assign sw_rdata = csr_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            epc_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ecall_req)
                epc_q <= cur_pc;
        end
    end

    // Outputs are held quiet while rst is high so a reset never acks or writes.
    always_comb begin
        state_nxt      = state;
        trap_ack       = 1'b0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        sw_ready       = 1'b0;
        csr_wen        = 1'b0;
        csr_waddr      = sw_addr;
        csr_wdata      = sw_wdata;
        csr_raddr      = sw_raddr;
        upd_mode       = MODE_TRAP;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (ecall_req) begin
                        trap_ack  = 1'b1;
                        busy      = 1'b1;
                        state_nxt = E_EPC;
                    end else if (mret_req) begin
                        trap_ack  = 1'b1;
                        busy      = 1'b1;
                        state_nxt = M_STAT;
                    end else begin
                        sw_ready = 1'b1;
                        csr_wen  = sw_wen;
                    end
                end
                E_EPC: begin
                    busy      = 1'b1;
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MEPC;
                    csr_wdata = epc_q;
                    state_nxt = E_CAUSE;
                end
                E_CAUSE: begin
                    busy      = 1'b1;
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MCAUSE;
                    csr_wdata = MCAUSE_ECALL;
                    state_nxt = E_STAT;
                end
                E_STAT: begin
                    busy      = 1'b1;
                    csr_raddr = CSR_MSTATUS;
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MSTATUS;
                    csr_wdata = mstat_new;
                    state_nxt = E_JUMP;
                end
                E_JUMP: begin
                    busy           = 1'b1;
                    csr_raddr      = CSR_MTVEC;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[31:2], 2'b00};
                    state_nxt      = IDLE;
                end
                M_STAT: begin
                    busy      = 1'b1;
                    upd_mode  = MODE_RET;
                    csr_raddr = CSR_MSTATUS;
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MSTATUS;
                    csr_wdata = mstat_new;
                    state_nxt = M_JUMP;
                end
                M_JUMP: begin
                    busy           = 1'b1;
                    csr_raddr      = CSR_MEPC;
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_rdata;
                    state_nxt      = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_trap_seq.sv
// Scoreboard bench for the trap sequencer with a behavioural CSR file.
module tb_ysyx_25030093_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_req, mret_req;
    logic [31:0] cur_pc;
    logic        trap_ack, busy, redirect_valid;
    logic [31:0] redirect_pc;
    logic        sw_wen, sw_ready;
    logic [11:0] sw_addr, sw_raddr;
    logic [31:0] sw_wdata, sw_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata;

    ysyx_25030093_trap_seq #(.MCAUSE_ECALL(32'd11)) dut (
        .clk            (clk),
        .rst            (rst),
        .ecall_req      (ecall_req),
        .mret_req       (mret_req),
        .cur_pc         (cur_pc),
        .trap_ack       (trap_ack),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .sw_wen         (sw_wen),
        .sw_addr        (sw_addr),
        .sw_wdata       (sw_wdata),
        .sw_ready       (sw_ready),
        .sw_raddr       (sw_raddr),
        .sw_rdata       (sw_rdata),
        .csr_wen        (csr_wen),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] csr_mem [0:4095];
    assign csr_rdata = csr_mem[csr_raddr];
    always @(posedge clk) if (csr_wen) csr_mem[csr_waddr] <= csr_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] pc; int lat; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cyc = 0;
    int redir_cyc = 0;
    int sw_cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_wr(logic [11:0] a, logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic push_rd(logic [31:0] pc, int lat);
        rd_t r;
        r.pc = pc;
        r.lat = lat;
        rd_q.push_back(r);
    endtask

    // Monitor: every CSR write and redirect must match the next queued entry.
    initial begin
        wr_t w;
        rd_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (trap_ack) ack_cyc = cyc;
                if (csr_wen) begin
                    if (wr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_csr_write: got addr %h data %h, none required",
                                 csr_waddr, csr_wdata);
                    end else begin
                        w = wr_q.pop_front();
                        chk("csr_waddr", {20'h0, csr_waddr}, {20'h0, w.addr});
                        chk("csr_wdata", csr_wdata, w.data);
                        if (csr_waddr == 12'h340) sw_cyc = cyc;
                    end
                end
                if (redirect_valid) begin
                    redir_cyc = cyc;
                    if (rd_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_redirect: got pc %h, none required", redirect_pc);
                    end else begin
                        r = rd_q.pop_front();
                        chk("redirect_pc", redirect_pc, r.pc);
                        chk("redirect_latency", cyc - ack_cyc, r.lat);
                    end
                end
            end
        end
    end

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (trap_ack) seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no trap_ack, required one");
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (wr_q.size() == 0 && rd_q.size() == 0 && !busy) done = 1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d writes %0d redirects pending, required 0",
                     wr_q.size(), rd_q.size());
            wr_q.delete();
            rd_q.delete();
        end
    endtask

    task automatic sw_write(logic [11:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        sw_wen = 1'b1;
        sw_addr = a;
        sw_wdata = d;
        push_wr(a, d);
        @(negedge clk);
        chk("sw_ready_idle", sw_ready, 1);
        @(posedge clk);
        #1;
        sw_wen = 1'b0;
    endtask

    task automatic trap(logic e, logic m, logic [31:0] pc);
        @(posedge clk);
        #1;
        ecall_req = e;
        mret_req = m;
        cur_pc = pc;
        wait_ack();
        @(posedge clk);
        #1;
        ecall_req = 1'b0;
        mret_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ecall_req = 1'b1;
        mret_req = 1'b0;
        cur_pc = 32'h0;
        sw_wen = 1'b0;
        sw_addr = 12'h0;
        sw_wdata = 32'h0;
        sw_raddr = 12'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trap_ack", trap_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_csr_wen", csr_wen, 0);
        ecall_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ecall entry
        sw_write(12'h305, 32'h8000_0100);
        sw_write(12'h300, 32'h0000_1808);
        push_wr(12'h341, 32'h8000_0040);
        push_wr(12'h342, 32'd11);
        push_wr(12'h300, 32'h0000_1880);
        push_rd(32'h8000_0100, 4);
        trap(1'b1, 1'b0, 32'h8000_0040);
        drain();
        chk("ecall_mepc", csr_mem[12'h341], 32'h8000_0040);
        chk("ecall_mcause", csr_mem[12'h342], 32'd11);
        chk("ecall_mstatus", csr_mem[12'h300], 32'h0000_1880);

        // mret
        sw_write(12'h341, 32'h8000_0044);
        push_wr(12'h300, 32'h0000_1888);
        push_rd(32'h8000_0044, 2);
        trap(1'b0, 1'b1, 32'h0);
        drain();
        chk("mret_mstatus", csr_mem[12'h300], 32'h0000_1888);

        // ecall and mret together: ecall first, mret after ecall drops
        push_wr(12'h341, 32'h8000_0050);
        push_wr(12'h342, 32'd11);
        push_wr(12'h300, 32'h0000_1880);
        push_rd(32'h8000_0100, 4);
        push_wr(12'h300, 32'h0000_1888);
        push_rd(32'h8000_0050, 2);
        @(posedge clk);
        #1;
        ecall_req = 1'b1;
        mret_req = 1'b1;
        cur_pc = 32'h8000_0050;
        wait_ack();
        @(posedge clk);
        #1;
        ecall_req = 1'b0;
        wait_ack();
        @(posedge clk);
        #1;
        mret_req = 1'b0;
        drain();
        chk("both_mepc", csr_mem[12'h341], 32'h8000_0050);
        chk("both_mstatus", csr_mem[12'h300], 32'h0000_1888);

        // sw write colliding with ecall; misaligned mtvec
        sw_write(12'h305, 32'h8000_0103);
        push_wr(12'h341, 32'h8000_0060);
        push_wr(12'h342, 32'd11);
        push_wr(12'h300, 32'h0000_1880);
        push_rd(32'h8000_0100, 4);
        push_wr(12'h340, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        ecall_req = 1'b1;
        cur_pc = 32'h8000_0060;
        sw_wen = 1'b1;
        sw_addr = 12'h340;
        sw_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("collide_sw_ready", sw_ready, 0);
        chk("collide_trap_ack", trap_ack, 1);
        @(posedge clk);
        #1;
        ecall_req = 1'b0;
        begin
            bit rdy = 0;
            for (int i = 0; i < 20 && !rdy; i++) begin
                @(negedge clk);
                if (sw_ready) rdy = 1;
            end
            chk("retry_sw_ready", rdy, 1);
        end
        @(posedge clk);
        #1;
        sw_wen = 1'b0;
        drain();
        chk("sw_after_redirect", sw_cyc > redir_cyc, 1);
        chk("mscratch", csr_mem[12'h340], 32'hDEAD_BEEF);
        sw_raddr = 12'h340;
        #1;
        chk("sw_rdata", sw_rdata, 32'hDEAD_BEEF);

        // reset while in E_CAUSE
        sw_write(12'h342, 32'h0000_0005);
        push_wr(12'h341, 32'h8000_0070);
        @(posedge clk);
        #1;
        ecall_req = 1'b1;
        cur_pc = 32'h8000_0070;
        wait_ack();
        @(posedge clk);
        #1;
        ecall_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_csr_wen", csr_wen, 0);
        chk("abort_redirect", redirect_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("abort_wr_pending", wr_q.size(), 0);
        chk("abort_mepc", csr_mem[12'h341], 32'h8000_0070);
        chk("abort_mcause", csr_mem[12'h342], 32'h0000_0005);
        chk("abort_idle", sw_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
